mycpu_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute stage. The ALU covers single-cycle integer ops; this block handles the long-latency MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- Execute stage issues an op with a start pulse and stalls on busy. MFHI/MFLO read hi/lo directly.
- Pipeline flush cancels an in-flight op.

---
 rtl/mycpu_pkg.sv | 25 ++
 rtl/mycpu_muldiv_step.sv | 30 +++
 rtl/mycpu_muldiv.sv | 137 +++++++++++++
 tb/tb_mycpu_muldiv.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared definitions for the mycpu execute-stage units.
// Mul/div op codes, FSM state encoding and iteration count.
package mycpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ITER       = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIN  = 2'b10
    } md_state_e;

    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? -v : v;
    endfunction

endpackage

// File: rtl/mycpu_muldiv_step.sv
// One iteration of the mul/div datapath: shift-add multiply or
// restoring divide on a 64-bit {upper, lower} accumulator.
module mycpu_muldiv_step
    import mycpu_pkg::*;
(
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next,
    output logic        q_bit
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] rem;

    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        shifted  = acc[63:31];
        rem      = shifted[31:0] - operand;
        q_bit    = 1'b0;
        acc_next = {sum, acc[31:1]};
        if (is_div) begin
            // quotient bit is merged into bit 0 by the caller
            q_bit    = (shifted >= {1'b0, operand});
            acc_next = {q_bit ? rem : shifted[31:0], acc[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mycpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Operands are reduced to magnitudes; signs are restored in FIN.
module mycpu_muldiv
    import mycpu_pkg::*;
#(
    parameter int DATA_WIDTH = mycpu_pkg::DATA_WIDTH,
    parameter int ITER       = mycpu_pkg::ITER
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    md_state_e   state;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] opnd;
    logic [31:0] a_raw;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic        q_bit;

    logic        sa_in;
    logic        sb_in;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        sa_in = ~op[0] & a[31];
        sb_in = ~op[0] & b[31];
        ma    = neg_if(sa_in, a);
        mb    = neg_if(sb_in, b);
    end

    mycpu_muldiv_step u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_next),
        .q_bit    (q_bit)
    );

    // sign flags are only ever set for the signed ops
    always_comb begin
        prod   = (neg_a ^ neg_b) ? -acc : acc;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_if(neg_a, acc[63:32]);
                res_lo = neg_if(neg_a ^ neg_b, acc[31:0]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MD_IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    done <= 1'b0;
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !cancel) begin
                        state    <= MD_CALC;
                        busy     <= 1'b1;
                        count    <= '0;
                        is_div   <= op[1];
                        neg_a    <= sa_in;
                        neg_b    <= sb_in;
                        div_zero <= (b == '0);
                        a_raw    <= a;
                        opnd     <= op[1] ? mb : ma;
                        acc      <= {32'd0, op[1] ? ma : mb};
                    end
                end
                MD_CALC: begin
                    if (cancel) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc   <= acc_next | {63'd0, q_bit};
                        count <= count + 5'd1;
                        if (count == 5'(ITER - 1)) state <= MD_FIN;
                    end
                end
                MD_FIN: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mycpu_muldiv.sv
// Scoreboard bench for mycpu_muldiv: expected HI/LO and done cycle
// are queued at issue and compared when done pulses.
module tb_mycpu_muldiv;
    import mycpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mycpu_muldiv dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        int          qi;
        int          ri;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (o)
            2'b00: p = sx * sy;
            2'b01: p = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 0) p = {x, 32'hFFFFFFFF};
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
                    p = {32'd0, 32'h80000000};
                else begin
                    qi = $signed(x) / $signed(y);
                    ri = $signed(x) % $signed(y);
                    p  = {ri, qi};
                end
            end
            default: begin
                if (y == 0) p = {x, 32'hFFFFFFFF};
                else p = {x % y, x / y};
            end
        endcase
        return p;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.tag, "_lat"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic issue(input string tag, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input bit track);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            e.tag = tag;
            {e.hi, e.lo} = model(o, x, y);
            e.due = cyc + 33;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(output int busy_cyc);
        busy_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) return;
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       output int busy_cyc);
        issue(tag, o, x, y, 1'b1);
        wait_done(busy_cyc);
    endtask

    initial begin
        int bc;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        cancel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
        check("multu_busy_cycles", 64'(bc), 64'd33);
        run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, bc);
        check("mult_busy_cycles", 64'(bc), 64'd33);
        run("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, bc);
        run("divu_small", 2'b11, 32'd7, 32'd2, bc);
        run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, bc);
        run("divu_zero", 2'b11, 32'd5, 32'd0, bc);
        run("div_zero_neg", 2'b10, 32'hFFFFFFFB, 32'd0, bc);
        run("div_neg_div", 2'b10, 32'd100, 32'hFFFFFFF9, bc);
        for (int i = 0; i < 4; i++)
            run("rand", 2'(i), $urandom, $urandom_range(1, 32'h0001FFFF), bc);

        hi_we = 1'b1;
        wdata = 32'h1234;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h5678;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check("mthi", 64'(hi), 64'h1234);
        check("mtlo", 64'(lo), 64'h5678);

        issue("divu_cancel", 2'b11, 32'd100, 32'd3, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd9;
        hi_we = 1'b1;
        wdata = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        check("busy_mid_op", 64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("cancel_hi", 64'(hi), 64'h1234);
        check("cancel_lo", 64'(lo), 64'h5678);
        check("cancel_idle_busy", 64'(busy), 64'd0);

        start  = 1'b1;
        cancel = 1'b1;
        lo_we  = 1'b1;
        wdata  = 32'h9ABC;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        lo_we  = 1'b0;
        check("idle_cancel_busy", 64'(busy), 64'd0);
        check("idle_cancel_mtlo", 64'(lo), 64'h9ABC);

        issue("mult_rst", 2'b00, 32'hFFFFFFFD, 32'd7, 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run("multu_after_rst", 2'b01, 32'd2, 32'd3, bc);
        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
